mux_canales_rr: RTL and testbench



---
 rtl/mux_canales_rr.sv | 134 +++++++++++++
 tb/tb_mux_canales_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_canales_rr.sv
// Parametrised N-channel registered multiplexer with valid/ready handshake,
// fixed or round-robin selection. Optional grant counter: `define MUX_CONTADOR_EN.
module mux_canales_rr #(
   parameter  int ANCHO   = 8,
   parameter  int CANALES = 6,
   localparam int SEL_W   = $clog2(CANALES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       modo,
   input  logic [SEL_W-1:0]           sel,
   input  logic [CANALES*ANCHO-1:0]   entrada,
   input  logic [CANALES-1:0]         entrada_valida,
   output logic [CANALES-1:0]         entrada_listo,
   output logic [ANCHO-1:0]           salida,
   output logic                       salida_valida,
   input  logic                       salida_listo,
   output logic [SEL_W-1:0]           canal,
   output logic                       error_sel
`ifdef MUX_CONTADOR_EN
   ,
   output logic [15:0]                conteo
`endif
);

   localparam int EXT = 2 ** SEL_W;

   logic [ANCHO-1:0]   salida_r;
   logic               salida_valida_r;
   logic [SEL_W-1:0]   canal_r;
   logic               error_sel_r;
   logic [SEL_W-1:0]   ptr_r;

   logic               carga_s;
   logic               sel_ok_s;
   logic [EXT-1:0]     valida_ext_s;
   logic [EXT-1:0]     listo_ext_s;
   logic               rr_hit_s;
   logic [SEL_W-1:0]   rr_idx_s;
   logic               gnt_s;
   logic [SEL_W-1:0]   gnt_idx_s;
   int                 cand_s;

   assign carga_s  = !salida_valida_r || salida_listo;
   assign sel_ok_s = (int'(sel) < CANALES);

   // Grant arbitration: fixed index or round-robin search starting after ptr_r.
   always_comb begin
      valida_ext_s                = '0;
      valida_ext_s[CANALES-1:0]   = entrada_valida;
      rr_hit_s                    = 1'b0;
      rr_idx_s                    = '0;
      cand_s                      = 0;
      gnt_s                       = 1'b0;
      gnt_idx_s                   = '0;
      for (int k = 1; k <= CANALES; k++) begin
         cand_s = int'(ptr_r) + k;
         if (cand_s >= CANALES) begin
            cand_s = cand_s - CANALES;
         end else begin
            cand_s = cand_s;
         end
         if (!rr_hit_s && valida_ext_s[cand_s[SEL_W-1:0]]) begin
            rr_hit_s = 1'b1;
            rr_idx_s = cand_s[SEL_W-1:0];
         end else begin
            rr_hit_s = rr_hit_s;
         end
      end
      if (modo) begin
         gnt_s     = rr_hit_s && carga_s;
         gnt_idx_s = rr_idx_s;
      end else begin
         gnt_s     = sel_ok_s && valida_ext_s[sel] && carga_s;
         gnt_idx_s = sel;
      end
   end

   // One-hot ready toward the granted producer, silenced while in reset.
   always_comb begin
      listo_ext_s = '0;
      if (gnt_s && !rst) begin
         listo_ext_s[gnt_idx_s] = 1'b1;
      end else begin
         listo_ext_s = '0;
      end
   end

   assign entrada_listo = listo_ext_s[CANALES-1:0];

   // Output stage, round-robin pointer and select-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         salida_r        <= {ANCHO{1'b0}};
         salida_valida_r <= 1'b0;
         canal_r         <= {SEL_W{1'b0}};
         error_sel_r     <= 1'b0;
         ptr_r           <= SEL_W'(CANALES - 1);
      end else begin
         if (gnt_s) begin
            salida_r        <= entrada[gnt_idx_s*ANCHO +: ANCHO];
            canal_r         <= gnt_idx_s;
            salida_valida_r <= 1'b1;
         end else if (salida_valida_r && salida_listo) begin
            salida_valida_r <= 1'b0;
         end
         error_sel_r <= !modo && !sel_ok_s;
         if (modo && gnt_s) begin
            ptr_r <= gnt_idx_s;
         end
      end
   end

`ifdef MUX_CONTADOR_EN
   logic [15:0] conteo_r;

   // Saturating count of accepted input transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         conteo_r <= 16'd0;
      end else if (gnt_s && (conteo_r != 16'hFFFF)) begin
         conteo_r <= conteo_r + 16'd1;
      end
   end

   assign conteo = conteo_r;
`endif

   assign salida        = salida_r;
   assign salida_valida = salida_valida_r;
   assign canal         = canal_r;
   assign error_sel     = error_sel_r;

endmodule

// File: tb/tb_mux_canales_rr.sv
// Directed table-driven bench for mux_canales_rr (ANCHO=8, CANALES=6).
module tb_mux_canales_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic        modo;
   logic [2:0]  sel;
   logic [47:0] entrada;
   logic [5:0]  entrada_valida;
   logic [5:0]  entrada_listo;
   logic [7:0]  salida;
   logic        salida_valida;
   logic        salida_listo;
   logic [2:0]  canal;
   logic        error_sel;
`ifdef MUX_CONTADOR_EN
   logic [15:0] conteo;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_canales_rr #(.ANCHO(8), .CANALES(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .modo           (modo),
      .sel            (sel),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .entrada_listo  (entrada_listo),
      .salida         (salida),
      .salida_valida  (salida_valida),
      .salida_listo   (salida_listo),
      .canal          (canal),
      .error_sel      (error_sel)
`ifdef MUX_CONTADOR_EN
      ,
      .conteo         (conteo)
`endif
   );

   typedef struct {
      logic       r;
      logic       m;
      logic [2:0] s;
      logic [5:0] val;
      logic       sl;
      logic [7:0] d0;
      logic [5:0] e_listo;
      logic [7:0] e_sal;
      logic       e_val;
      logic [2:0] e_can;
      logic       e_err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic m, input logic [2:0] s, input logic [5:0] val,
                      input logic sl, input logic [7:0] d0, input logic [5:0] e_listo,
                      input logic [7:0] e_sal, input logic e_val, input logic [2:0] e_can,
                      input logic e_err);
      vec_t v;
      v.r = r; v.m = m; v.s = s; v.val = val; v.sl = sl; v.d0 = d0;
      v.e_listo = e_listo; v.e_sal = e_sal; v.e_val = e_val; v.e_can = e_can; v.e_err = e_err;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      rst            = v.r;
      modo           = v.m;
      sel            = v.s;
      entrada_valida = v.val;
      salida_listo   = v.sl;
      entrada[7:0]   = v.d0;
      #1;
      chk({tag, " entrada_listo"}, 16'(entrada_listo), 16'(v.e_listo));
      @(posedge clk);
      #1;
      chk({tag, " salida"}, 16'(salida), 16'(v.e_sal));
      chk({tag, " salida_valida"}, 16'(salida_valida), 16'(v.e_val));
      chk({tag, " canal"}, 16'(canal), 16'(v.e_can));
      chk({tag, " error_sel"}, 16'(error_sel), 16'(v.e_err));
   endtask

   initial begin
      rst            = 1'b1;
      modo           = 1'b0;
      sel            = 3'd0;
      entrada        = {8'hE6, 8'hE5, 8'hE4, 8'hE3, 8'hE2, 8'hE1};
      entrada_valida = 6'b111111;
      salida_listo   = 1'b1;

      //   rst   modo  sel   valid      sl    d0     listo      salida  v     canal err
      add(1'b1, 1'b0, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000000, 8'h00, 1'b0, 3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000001, 8'hE1, 1'b1, 3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd0, 6'b111111, 1'b1, 8'hEA, 6'b000001, 8'hEA, 1'b1, 3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd1, 6'b111111, 1'b1, 8'hE1, 6'b000010, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b0, 3'd2, 6'b111111, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);
      add(1'b0, 1'b0, 3'd3, 6'b111111, 1'b1, 8'hE1, 6'b001000, 8'hE4, 1'b1, 3'd3, 1'b0);
      add(1'b0, 1'b0, 3'd4, 6'b111111, 1'b1, 8'hE1, 6'b010000, 8'hE5, 1'b1, 3'd4, 1'b0);
      add(1'b0, 1'b0, 3'd5, 6'b111111, 1'b1, 8'hE1, 6'b100000, 8'hE6, 1'b1, 3'd5, 1'b0);
      add(1'b0, 1'b0, 3'd6, 6'b111111, 1'b1, 8'hE1, 6'b000000, 8'hE6, 1'b0, 3'd5, 1'b1);
      add(1'b0, 1'b0, 3'd7, 6'b111111, 1'b1, 8'hE1, 6'b000000, 8'hE6, 1'b0, 3'd5, 1'b1);
      add(1'b0, 1'b0, 3'd2, 6'b111111, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);
      // Round-robin from reset: 0..5 then wrap to 0.
      add(1'b1, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000000, 8'h00, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'(1 << k), 8'(8'hE1 + k), 1'b1, 3'(k), 1'b0);
      end
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000001, 8'hE1, 1'b1, 3'd0, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b100100, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b100100, 1'b1, 8'hE1, 6'b100000, 8'hE6, 1'b1, 3'd5, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b100100, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b100100, 1'b1, 8'hE1, 6'b100000, 8'hE6, 1'b1, 3'd5, 1'b0);
      // Backpressure: grant ch1, hold three cycles, release with reload.
      add(1'b0, 1'b1, 3'd0, 6'b000010, 1'b1, 8'hE1, 6'b000010, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b0, 8'hE1, 6'b000000, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b0, 8'hE1, 6'b000000, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b0, 8'hE1, 6'b000000, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);
      // Reset mid-stream, then first grant is ch0.
      add(1'b1, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000000, 8'h00, 1'b0, 3'd0, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'b111111, 1'b1, 8'hE1, 6'b000001, 8'hE1, 1'b1, 3'd0, 1'b0);
      // Out-of-range sel ignored in round-robin; ptr kept across a fixed-mode grant.
      add(1'b0, 1'b1, 3'd7, 6'b111111, 1'b1, 8'hE1, 6'b000010, 8'hE2, 1'b1, 3'd1, 1'b0);
      add(1'b0, 1'b0, 3'd4, 6'b111111, 1'b1, 8'hE1, 6'b010000, 8'hE5, 1'b1, 3'd4, 1'b0);
      add(1'b0, 1'b1, 3'd4, 6'b111111, 1'b1, 8'hE1, 6'b000100, 8'hE3, 1'b1, 3'd2, 1'b0);

      foreach (vq[i]) begin
         apply(vq[i], $sformatf("v%0d", i));
      end

      // Hand sequence: no producers valid, stall two cycles, then drain.
      @(negedge clk);
      entrada_valida = 6'b000000;
      salida_listo   = 1'b0;
      #1;
      chk("idle listo", 16'(entrada_listo), 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      chk("stall valida", 16'(salida_valida), 16'h0001);
      chk("stall salida", 16'(salida), 16'h00E3);
      @(negedge clk);
      salida_listo = 1'b1;
      @(posedge clk);
      #1;
      chk("drain valida", 16'(salida_valida), 16'h0000);
      chk("drain salida", 16'(salida), 16'h00E3);
      chk("drain canal", 16'(canal), 16'h0002);

`ifdef MUX_CONTADOR_EN
      @(negedge clk);
      rst = 1'b1;
      modo = 1'b1;
      entrada_valida = 6'b111111;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("conteo 10", conteo, 16'd10);
      @(negedge clk);
      force dut.conteo_r = 16'hFFFE;
      #1;
      release dut.conteo_r;
      repeat (3) @(posedge clk);
      #1;
      chk("conteo sat", conteo, 16'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
